// File: rtl/axi_sram_slave_if.sv
// ---------------------------------------------------------------------------
// axi_sram_slave_if
// Bundles the AXI-style burst channels between the data cache (master) and
// the on-chip SRAM (slave).
//
// Channels:
//   AR : araddr, arlen, arsize, arburst, arvalid -> / <- arready
//   R  : <- rdata, rvalid, rlast / rready ->
//   AW : awaddr, awlen, awsize, awburst, awvalid -> / <- awready
//   W  : wdata, wstrb, wvalid, wlast -> / <- wready
//   B  : <- bvalid / bready ->
//
// Handshake rule (every channel): a transfer happens on a rising clock edge
// where both valid and ready are high. The source holds its payload and
// valid stable until that edge; ready may change freely while valid is low.
// ---------------------------------------------------------------------------
interface axi_sram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // read address channel
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  // read data channel
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rvalid;
  logic                    rready;
  logic                    rlast;
  // write address channel
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  // write data channel
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic                    wlast;
  // write response channel
  logic                    bvalid;
  logic                    bready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rvalid, rlast,
    output rready,
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wvalid, wlast,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rvalid, rlast,
    input  rready,
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wvalid, wlast,
    output wready,
    output bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
// Word-addressed on-chip SRAM behind AXI-style burst channels. Serves the
// data cache's line refills (AR/R) and dirty-line write-backs (AW/W/B).
// The read and write channels are independent FSMs sharing one array, so
// neither channel ever stalls the other. Storage contents are not reset and
// start undefined.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   bus        slave modport of axi_sram_slave_if (AR, R, AW, W, B)
//   o_rd_state out  read FSM state  (debug)
//   o_wr_state out  write FSM state (debug)
//
// Addressing: word index = addr[log2(MEM_WORDS)+1:2]; byte offset and upper
// address bits are ignored, so addresses alias modulo MEM_WORDS. Only 4-byte
// beats exist; arsize/awsize are ignored. FIXED bursts hold the index, any
// other burst type steps it by one word per beat, wrapping at MEM_WORDS.
//
// Same-word read and write in one cycle: the read register samples the array
// before the write lands at that edge, so the read returns the old data.
// ---------------------------------------------------------------------------
module axi_sram_slave #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_WORDS    = 4096,
  parameter int READ_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  axi_sram_slave_if.slave    bus,
  output logic [1:0]         o_rd_state,
  output logic [1:0]         o_wr_state
);

  localparam int              IDX_W       = $clog2(MEM_WORDS);
  localparam int              STRB_W      = DATA_WIDTH / 8;
  localparam logic [1:0]      BURST_FIXED = 2'b00;
  // last value of the latency counter before data is presented
  localparam logic [2:0]      LAT_LAST    = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                input logic [1:0]       burst);
    next_idx = (burst == BURST_FIXED) ? idx : idx + IDX_W'(1);
  endfunction

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  // ready outputs stay low while reset is held and for the release cycle
  logic r_live;

  // -------------------------------------------------------------------------
  // Read channel state
  // -------------------------------------------------------------------------
  rd_state_e             r_rd_state;
  logic [IDX_W-1:0]      r_rd_idx;
  logic [7:0]            r_rd_len;
  logic [1:0]            r_rd_burst;
  logic [7:0]            r_rd_beat;
  logic [2:0]            r_rd_lat;
  logic [DATA_WIDTH-1:0] r_rdata;

  rd_state_e             w_rd_state_nxt;
  logic [IDX_W-1:0]      w_rd_idx_nxt;
  logic [7:0]            w_rd_len_nxt;
  logic [1:0]            w_rd_burst_nxt;
  logic [7:0]            w_rd_beat_nxt;
  logic [2:0]            w_rd_lat_nxt;
  logic                  w_rd_fetch;
  logic [IDX_W-1:0]      w_rd_fetch_idx;
  logic [IDX_W-1:0]      w_ar_idx;
  logic [IDX_W-1:0]      w_rd_adv;
  logic                  w_ar_hs;

  // -------------------------------------------------------------------------
  // Write channel state
  // -------------------------------------------------------------------------
  wr_state_e             r_wr_state;
  logic [IDX_W-1:0]      r_wr_idx;
  logic [7:0]            r_wr_len;
  logic [1:0]            r_wr_burst;
  logic [7:0]            r_wr_beat;

  wr_state_e             w_wr_state_nxt;
  logic [IDX_W-1:0]      w_wr_idx_nxt;
  logic [7:0]            w_wr_len_nxt;
  logic [1:0]            w_wr_burst_nxt;
  logic [7:0]            w_wr_beat_nxt;
  logic                  w_mem_we;
  logic [IDX_W-1:0]      w_aw_idx;
  logic                  w_aw_hs;
  logic                  w_w_hs;

  // size fields, wlast and the ignored address bits are intentionally unused
  logic                  w_unused;
  assign w_unused = ^{bus.arsize, bus.awsize, bus.wlast,
                      bus.araddr[ADDR_WIDTH-1:IDX_W+2], bus.araddr[1:0],
                      bus.awaddr[ADDR_WIDTH-1:IDX_W+2], bus.awaddr[1:0]};

  assign w_ar_idx = bus.araddr[IDX_W+1:2];
  assign w_aw_idx = bus.awaddr[IDX_W+1:2];
  assign w_rd_adv = next_idx(r_rd_idx, r_rd_burst);

  assign w_ar_hs  = bus.arvalid && bus.arready;
  assign w_aw_hs  = bus.awvalid && bus.awready;
  assign w_w_hs   = bus.wvalid && (r_wr_state == W_DATA);

  // -------------------------------------------------------------------------
  // Channel outputs
  // -------------------------------------------------------------------------
  assign bus.arready = r_live && (r_rd_state == R_IDLE);
  assign bus.rvalid  = (r_rd_state == R_DATA);
  assign bus.rlast   = (r_rd_state == R_DATA) && (r_rd_beat == r_rd_len);
  assign bus.rdata   = r_rdata;

  assign bus.awready = r_live && (r_wr_state == W_IDLE);
  assign bus.wready  = (r_wr_state == W_DATA);
  assign bus.bvalid  = (r_wr_state == W_RESP);

  assign o_rd_state  = r_rd_state;
  assign o_wr_state  = r_wr_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Read FSM: next state and datapath controls
  // rdata is only reloaded when a new beat is presented (entry to R_DATA or
  // an accepted non-final beat), which keeps it stable under backpressure.
  // -------------------------------------------------------------------------
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_idx_nxt   = r_rd_idx;
    w_rd_len_nxt   = r_rd_len;
    w_rd_burst_nxt = r_rd_burst;
    w_rd_beat_nxt  = r_rd_beat;
    w_rd_lat_nxt   = r_rd_lat;
    w_rd_fetch     = 1'b0;
    w_rd_fetch_idx = r_rd_idx;
    case (r_rd_state)
      R_IDLE: begin
        if (w_ar_hs) begin
          w_rd_idx_nxt   = w_ar_idx;
          w_rd_len_nxt   = bus.arlen;
          w_rd_burst_nxt = bus.arburst;
          w_rd_beat_nxt  = 8'd0;
          w_rd_lat_nxt   = 3'd0;
          if (READ_LATENCY == 0) begin
            w_rd_state_nxt = R_DATA;
            w_rd_fetch     = 1'b1;
            w_rd_fetch_idx = w_ar_idx;
          end else begin
            w_rd_state_nxt = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_rd_lat == LAT_LAST) begin
          w_rd_state_nxt = R_DATA;
          w_rd_fetch     = 1'b1;
        end else begin
          w_rd_lat_nxt = r_rd_lat + 3'd1;
        end
      end
      R_DATA: begin
        if (bus.rready) begin
          if (r_rd_beat == r_rd_len) begin
            w_rd_state_nxt = R_IDLE;
          end else begin
            w_rd_beat_nxt  = r_rd_beat + 8'd1;
            w_rd_idx_nxt   = w_rd_adv;
            w_rd_fetch     = 1'b1;
            w_rd_fetch_idx = w_rd_adv;
          end
        end
      end
      default: begin
        w_rd_state_nxt = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_state <= R_IDLE;
      r_rd_idx   <= '0;
      r_rd_len   <= '0;
      r_rd_burst <= '0;
      r_rd_beat  <= '0;
      r_rd_lat   <= '0;
      r_rdata    <= '0;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_rd_idx   <= w_rd_idx_nxt;
      r_rd_len   <= w_rd_len_nxt;
      r_rd_burst <= w_rd_burst_nxt;
      r_rd_beat  <= w_rd_beat_nxt;
      r_rd_lat   <= w_rd_lat_nxt;
      // samples the array before any same-edge write lands
      if (w_rd_fetch) begin
        r_rdata <= r_mem[w_rd_fetch_idx];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Write FSM: next state and array write enable
  // The burst length alone decides the final beat; wlast is not consulted.
  // -------------------------------------------------------------------------
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_idx_nxt   = r_wr_idx;
    w_wr_len_nxt   = r_wr_len;
    w_wr_burst_nxt = r_wr_burst;
    w_wr_beat_nxt  = r_wr_beat;
    w_mem_we       = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        if (w_aw_hs) begin
          w_wr_idx_nxt   = w_aw_idx;
          w_wr_len_nxt   = bus.awlen;
          w_wr_burst_nxt = bus.awburst;
          w_wr_beat_nxt  = 8'd0;
          w_wr_state_nxt = W_DATA;
        end
      end
      W_DATA: begin
        if (w_w_hs) begin
          w_mem_we = 1'b1;
          if (r_wr_beat == r_wr_len) begin
            w_wr_state_nxt = W_RESP;
          end else begin
            w_wr_beat_nxt = r_wr_beat + 8'd1;
            w_wr_idx_nxt  = next_idx(r_wr_idx, r_wr_burst);
          end
        end
      end
      W_RESP: begin
        if (bus.bready) begin
          w_wr_state_nxt = W_IDLE;
        end
      end
      default: begin
        w_wr_state_nxt = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_state <= W_IDLE;
      r_wr_idx   <= '0;
      r_wr_len   <= '0;
      r_wr_burst <= '0;
      r_wr_beat  <= '0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_wr_idx   <= w_wr_idx_nxt;
      r_wr_len   <= w_wr_len_nxt;
      r_wr_burst <= w_wr_burst_nxt;
      r_wr_beat  <= w_wr_beat_nxt;
    end
  end

  // byte-lane write; the array itself has no reset
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (bus.wstrb[i]) begin
          r_mem[r_wr_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_slave
// Directed and randomized bursts against axi_sram_slave. A word-array model
// of the SRAM is updated from the bench's own view of accepted write beats.
// Each read beat is expected to carry the model's word as it stood when the
// beat was first presented: captures happen one step after the clock edge,
// model writes two steps after it, so a write landing on the same edge as a
// read fetch is seen as old data by that read.
// ---------------------------------------------------------------------------
module tb_axi_sram_slave;

  localparam int         MEM_WORDS = 4096;
  localparam int         RL        = 3;
  localparam logic [1:0] FIXED     = 2'b00;
  localparam logic [1:0] INCR      = 2'b01;
  localparam logic [1:0] WRAP      = 2'b10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0] unused_rd_state;
  logic [1:0] unused_wr_state;

  axi_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_sram_slave #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .MEM_WORDS   (MEM_WORDS),
    .READ_LATENCY(RL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .o_rd_state(unused_rd_state),
    .o_wr_state(unused_wr_state)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] model   [MEM_WORDS];
  logic [31:0] wd      [256];
  logic [3:0]  ws      [256];
  logic [31:0] last_rd [256];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic int word_of(input logic [31:0] addr);
    return int'(addr[31:2]) % MEM_WORDS;
  endfunction

  function automatic int step_word(input int w, input logic [1:0] burst);
    return (burst == FIXED) ? w : (w + 1) % MEM_WORDS;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input int w, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++) begin
      if (s[i]) model[w][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  // ---------------- driver: read burst ----------------
  // rmode 0: rready always high, 1: rready pattern 1,0,0,1, 2: random
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input int rmode);
    int          w, beat, idle, t, pat;
    bit          fresh, seen, done;
    logic [31:0] exp_d;
    exp_d = '0;
    @(posedge clk); #1;
    bus.araddr  = addr;
    bus.arlen   = len;
    bus.arsize  = 3'($urandom_range(0, 7));
    bus.arburst = burst;
    bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < 64) begin
      @(posedge clk); #1;
      t++;
    end
    check("ar_accept", 32'(bus.arready), 32'd1);
    if (!bus.arready) begin
      bus.arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    w = word_of(addr); beat = 0; idle = 0; pat = 0; t = 0;
    fresh = 1'b1; seen = 1'b0; done = 1'b0;
    while (!done && t < 2000) begin
      if (bus.rvalid) begin
        if (!seen) begin
          check("r_latency", 32'(idle), 32'(RL));
          seen = 1'b1;
        end
        if (fresh) begin
          exp_d = model[w];
          fresh = 1'b0;
        end
        check("rdata", bus.rdata, exp_d);
        check("rlast", 32'(bus.rlast), 32'(beat == int'(len)));
        case (rmode)
          0:       bus.rready = 1'b1;
          1:       bus.rready = (pat % 4 == 0) || (pat % 4 == 3);
          default: bus.rready = 1'($urandom_range(0, 1));
        endcase
        pat++;
        if (bus.rready) begin
          last_rd[beat[7:0]] = bus.rdata;
          if (beat == int'(len)) done = 1'b1;
          beat++;
          w = step_word(w, burst);
          fresh = 1'b1;
        end
      end else begin
        bus.rready = 1'($urandom_range(0, 1));
        if (!seen) idle++;
      end
      @(posedge clk); #1;
      t++;
    end
    bus.rready = 1'b0;
    check("r_done", 32'(done), 32'd1);
    check("rvalid_drop", 32'(bus.rvalid), 32'd0);
    check("arready_back", 32'(bus.arready), 32'd1);
  endtask

  // ---------------- driver: write burst (data from wd/ws) ----------------
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int wdelay,
                          input bit early_wlast, input bit gaps, input int bdelay);
    int w, beat, t;
    bit done;
    @(posedge clk); #2;
    bus.awaddr  = addr;
    bus.awlen   = len;
    bus.awsize  = 3'($urandom_range(0, 7));
    bus.awburst = burst;
    bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < 64) begin
      @(posedge clk); #2;
      t++;
    end
    check("aw_accept", 32'(bus.awready), 32'd1);
    if (!bus.awready) begin
      bus.awvalid = 1'b0;
      return;
    end
    @(posedge clk); #2;
    bus.awvalid = 1'b0;
    repeat (wdelay) begin
      @(posedge clk); #2;
    end
    w = word_of(addr); beat = 0; t = 0; done = 1'b0;
    while (!done && t < 2000) begin
      t++;
      if (gaps && $urandom_range(0, 4) == 0) begin
        bus.wvalid = 1'b0;
        @(posedge clk); #2;
        continue;
      end
      bus.wvalid = 1'b1;
      bus.wdata  = wd[beat[7:0]];
      bus.wstrb  = ws[beat[7:0]];
      bus.wlast  = early_wlast ? (beat == 1) : (beat == int'(len));
      if (bus.wready) begin
        @(posedge clk); #2;
        model_write(w, wd[beat[7:0]], ws[beat[7:0]]);
        if (beat == int'(len)) done = 1'b1;
        else check("bvalid_early", 32'(bus.bvalid), 32'd0);
        beat++;
        w = step_word(w, burst);
      end else begin
        @(posedge clk); #2;
      end
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    check("w_done", 32'(done), 32'd1);
    check("bvalid", 32'(bus.bvalid), 32'd1);
    repeat (bdelay) begin
      @(posedge clk); #2;
      check("bvalid_hold", 32'(bus.bvalid), 32'd1);
    end
    bus.bready = 1'b1;
    @(posedge clk); #2;
    bus.bready = 1'b0;
    check("bvalid_drop", 32'(bus.bvalid), 32'd0);
    check("awready_back", 32'(bus.awready), 32'd1);
  endtask

  task automatic fill_random(input int n, input bit rand_strb);
    for (int i = 0; i < n; i++) begin
      wd[i] = $urandom;
      ws[i] = rand_strb ? 4'($urandom_range(0, 15)) : 4'hF;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_arready"}, 32'(bus.arready), 32'd0);
    check({tag, "_awready"}, 32'(bus.awready), 32'd0);
    check({tag, "_rvalid"},  32'(bus.rvalid),  32'd0);
    check({tag, "_rlast"},   32'(bus.rlast),   32'd0);
    check({tag, "_wready"},  32'(bus.wready),  32'd0);
    check({tag, "_bvalid"},  32'(bus.bvalid),  32'd0);
    check({tag, "_rdata"},   bus.rdata,        32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] a;
    logic [7:0]  l;
    logic [1:0]  b;
    int          op;

    rst_n       = 1'b0;
    bus.araddr  = '0; bus.arlen = '0; bus.arsize = 3'd2; bus.arburst = INCR; bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    bus.awaddr  = '0; bus.awlen = '0; bus.awsize = 3'd2; bus.awburst = INCR; bus.awvalid = 1'b0;
    bus.wdata   = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.wlast = 1'b0;
    bus.bready  = 1'b0;

    // reset: everything quiet while held, ready one cycle after release
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_arready_pre", 32'(bus.arready), 32'd0);
    @(posedge clk); #1;
    check("rel_arready", 32'(bus.arready), 32'd1);
    check("rel_awready", 32'(bus.awready), 32'd1);

    // give every word a known value (also exercises 256-beat bursts)
    for (int blk = 0; blk < MEM_WORDS / 256; blk++) begin
      fill_random(256, 1'b0);
      do_write(32'(blk * 1024), 8'd255, INCR, 0, 1'b0, 1'b0, 0);
    end

    // directed line write-back and refill
    for (int i = 0; i < 8; i++) begin
      wd[i] = 32'hA0 + 32'(i);
      ws[i] = 4'hF;
    end
    do_write(32'h100, 8'd7, INCR, 0, 1'b0, 1'b0, 2);
    do_read(32'h100, 8'd7, INCR, 0);
    for (int i = 0; i < 8; i++) check("line_data", last_rd[i], 32'hA0 + 32'(i));

    // byte strobes
    wd[0] = 32'h1122_3344; ws[0] = 4'hF;
    do_write(32'h40, 8'd0, INCR, 0, 1'b0, 1'b0, 0);
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
    do_write(32'h40, 8'd0, INCR, 1, 1'b0, 1'b0, 0);
    do_read(32'h40, 8'd0, INCR, 0);
    check("strobe_merge", last_rd[0], 32'h11BB_33DD);

    // backpressure 1,0,0,1 on the line
    do_read(32'h100, 8'd7, INCR, 1);
    for (int i = 0; i < 8; i++) check("bp_data", last_rd[i], 32'hA0 + 32'(i));

    // wrap at the top of the array, plus an aliased address and WRAP type
    do_read(32'((MEM_WORDS - 2) * 4), 8'd3, INCR, 0);
    check("wrap_beat0", last_rd[0], model[MEM_WORDS - 2]);
    check("wrap_beat2", last_rd[2], model[0]);
    check("wrap_beat3", last_rd[3], model[1]);
    do_read(32'hFFFF_FFFB, 8'd3, WRAP, 2);
    check("alias_beat1", last_rd[1], model[MEM_WORDS - 1]);

    // FIXED burst: every beat hits one word, last beat wins
    fill_random(4, 1'b0);
    do_write(32'h200, 8'd3, FIXED, 0, 1'b0, 1'b0, 0);
    do_read(32'h200, 8'd3, FIXED, 0);
    for (int i = 0; i < 4; i++) check("fixed_data", last_rd[i], wd[3]);

    // early wlast must not end the burst
    fill_random(6, 1'b0);
    do_write(32'h300, 8'd5, INCR, 0, 1'b1, 1'b0, 1);
    do_read(32'h300, 8'd5, INCR, 0);
    check("early_wlast_b5", last_rd[5], wd[5]);

    // concurrent AR and AW on the same line
    fill_random(8, 1'b0);
    fork
      do_read(32'h100, 8'd7, INCR, 0);
      do_write(32'h100, 8'd7, INCR, 2, 1'b0, 1'b0, 1);
    join
    do_read(32'h100, 8'd7, INCR, 0);
    for (int i = 0; i < 8; i++) check("conc_after", last_rd[i], wd[i]);

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      a  = $urandom;
      l  = 8'($urandom_range(0, 15));
      b  = 2'($urandom_range(0, 2));
      op = $urandom_range(0, 2);
      fill_random(int'(l) + 1, 1'b1);
      if (op == 0) begin
        do_write(a, l, b, $urandom_range(0, 2), 1'b0, 1'b1, $urandom_range(0, 3));
      end else if (op == 1) begin
        do_read(a, l, b, $urandom_range(0, 2));
      end else begin
        fork
          do_read(a, l, b, $urandom_range(0, 2));
          do_write(a + 32'($urandom_range(0, 3) * 4), 8'($urandom_range(0, 15)),
                   2'($urandom_range(0, 2)), $urandom_range(0, 3), 1'b0, 1'b1,
                   $urandom_range(0, 2));
        join
      end
    end

    // reset in the middle of a stalled read burst
    @(posedge clk); #1;
    bus.araddr = 32'h100; bus.arlen = 8'd7; bus.arburst = INCR; bus.arvalid = 1'b1;
    bus.rready = 1'b0;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("mid_rvalid", 32'(bus.rvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rel_arready", 32'(bus.arready), 32'd1);
    check("mid_rel_awready", 32'(bus.awready), 32'd1);
    // array contents survive reset
    do_read(32'h100, 8'd7, INCR, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
